// File: rtl/counter_run_ctrl_pkg.sv
// Shared types and constants for the counter run controller.
// Holds the state encoding, default widths and stored-configuration reset values.
package counter_run_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_WIDTH     = 4;
    localparam int unsigned DEF_DIV_WIDTH = 4;

    // The stored limit resets to all-ones; replicate this bit to the limit width.
    localparam logic LIMIT_RST_BIT = 1'b1;
    localparam logic PERIODIC_RST  = 1'b0;

endpackage

// File: rtl/counter_run_ctrl_cnt.sv
// Counter datapath: count register with synchronous clear and increment,
// plus the terminal-count compare against the stored limit.
module counter_run_ctrl_cnt
    import counter_run_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    logic [WIDTH-1:0] r_count;

    // Clear has priority so a wrap at terminal count never also increments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count    = r_count;
    assign at_limit = (r_count == limit);

endmodule

// File: rtl/counter_run_ctrl.sv
// Run/stop sequencer for a WIDTH-bit up-counter with a registered terminal-count tick.
// Define COUNTER_RUN_CTRL_PRESCALE_EN to add the cfg_div prescaler input.
module counter_run_ctrl
    import counter_run_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DIV_WIDTH = DEF_DIV_WIDTH
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [WIDTH-1:0]     cfg_limit,
    input  logic                 cfg_periodic,
`ifdef COUNTER_RUN_CTRL_PRESCALE_EN
    input  logic [DIV_WIDTH-1:0] cfg_div,
`endif
    input  logic                 start,
    input  logic                 stop,
    output logic [WIDTH-1:0]     count,
    output logic                 busy,
    output logic                 tick
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_limit;
    logic             r_periodic;
    logic             r_tick;
    logic             w_cfg_fire;
    logic             w_advance;
    logic             w_at_limit;
    logic             w_clr;
    logic             w_inc;
    logic             w_tick_nxt;

    assign w_cfg_fire = cfg_valid && (r_state == IDLE);

`ifdef COUNTER_RUN_CTRL_PRESCALE_EN
    logic [DIV_WIDTH-1:0] r_div_q;
    logic [DIV_WIDTH-1:0] r_div;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_limit    <= {WIDTH{LIMIT_RST_BIT}};
            r_periodic <= PERIODIC_RST;
            r_div_q    <= '0;
        end else if (w_cfg_fire) begin
            r_limit    <= cfg_limit;
            r_periodic <= cfg_periodic;
            r_div_q    <= cfg_div;
        end
    end

    // Held at zero outside RUN, so every launch starts from a fresh divider phase.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_div <= '0;
        end else if ((r_state != RUN) || w_advance) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_WIDTH'(1);
        end
    end

    assign w_advance = (r_div == r_div_q);
`else
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_limit    <= {WIDTH{LIMIT_RST_BIT}};
            r_periodic <= PERIODIC_RST;
        end else if (w_cfg_fire) begin
            r_limit    <= cfg_limit;
            r_periodic <= cfg_periodic;
        end
    end

    assign w_advance = 1'b1;

    // DIV_WIDTH stays in the parameter list so both builds share one interface.
    if (DIV_WIDTH == 0) begin : g_no_prescaler
    end
`endif

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_state <= IDLE;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        w_tick_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = RUN;
                    w_clr       = 1'b1;
                end
            end
            RUN: begin
                // A terminal-count edge always wraps and ticks; stop only forces the exit.
                if (w_advance && w_at_limit) begin
                    w_clr      = 1'b1;
                    w_tick_nxt = 1'b1;
                    if (!r_periodic || stop) begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_inc = w_advance && !stop;
                    if (stop) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    counter_run_ctrl_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk      (CLK),
        .rst      (ASYNCRESET),
        .clr      (w_clr),
        .inc      (w_inc),
        .limit    (r_limit),
        .count    (count),
        .at_limit (w_at_limit)
    );

    assign cfg_ready = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign tick      = r_tick;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Self-checking bench for counter_run_ctrl: directed and random runs against
// closed-form expectations for count, tick and busy per cycle.
module tb_counter_run_ctrl;

    logic       CLK = 1'b0;
    logic       ASYNCRESET = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_limit = '0;
    logic       cfg_periodic = 1'b0;
`ifdef COUNTER_RUN_CTRL_PRESCALE_EN
    logic [3:0] cfg_div = '0;
`endif
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] count;
    logic       busy;
    logic       tick;

    int n_err = 0;
    int n_chk = 0;

    // Configuration the controller is expected to hold.
    int ms_limit = 15;
    bit ms_per   = 1'b0;
    int ms_div   = 0;

    always #5 CLK = ~CLK;

    counter_run_ctrl #(
        .WIDTH     (4),
        .DIV_WIDTH (4)
    ) dut (
        .CLK          (CLK),
        .ASYNCRESET   (ASYNCRESET),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_limit    (cfg_limit),
        .cfg_periodic (cfg_periodic),
`ifdef COUNTER_RUN_CTRL_PRESCALE_EN
        .cfg_div      (cfg_div),
`endif
        .start        (start),
        .stop         (stop),
        .count        (count),
        .busy         (busy),
        .tick         (tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Started at edge 0, the counter advances once per D cycles modulo L+1.
    function automatic int m_count(input int c, input int L, input int D);
        return ((c - 1) / D) % (L + 1);
    endfunction

    function automatic bit m_tick(input int c, input int L, input int D);
        return (c >= 2) && (((c - 1) % (D * (L + 1))) == 0);
    endfunction

    // One launch; s = cycle in which stop is held (0 = none); hold keeps a new
    // configuration offered throughout the run.
    task automatic run_case(input bit do_cfg, input int L, input bit per, input int d, input int s_in,
                            input bit hold, input int hL, input bit hper, input int hd);
        int  Lc, Dc, ncyc, cend, s, exp_count;
        bit  Pc, exp_busy, exp_tick, accept;
        if (do_cfg) begin
            cfg_valid    = 1'b1;
            cfg_limit    = 4'(L);
            cfg_periodic = per;
`ifdef COUNTER_RUN_CTRL_PRESCALE_EN
            cfg_div      = 4'(d);
`endif
            ms_limit = L;
            ms_per   = per;
            ms_div   = d;
        end
        Lc   = ms_limit;
        Pc   = ms_per;
        Dc   = ms_div + 1;
        ncyc = Dc * (Lc + 1) * 2 + 3;
        cend = Dc * (Lc + 1);
        s    = s_in;
        if (s >= ncyc - 2) s = ncyc - 3;
        if (Pc && s == 0) s = ncyc - 3;
        start = 1'b1;
        stop  = 1'b0;
        step();
        start = 1'b0;
        if (hold) begin
            cfg_valid    = 1'b1;
            cfg_limit    = 4'(hL);
            cfg_periodic = hper;
`ifdef COUNTER_RUN_CTRL_PRESCALE_EN
            cfg_div      = 4'(hd);
`endif
        end else begin
            cfg_valid = 1'b0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            if (s > 0 && c > s && (Pc || s <= cend)) begin
                exp_busy  = 1'b0;
                exp_tick  = (c == s + 1) && m_tick(s + 1, Lc, Dc);
                exp_count = m_tick(s + 1, Lc, Dc) ? 0 : m_count(s, Lc, Dc);
            end else if (!Pc && c > cend) begin
                exp_busy  = 1'b0;
                exp_tick  = (c == cend + 1);
                exp_count = 0;
            end else begin
                exp_busy  = 1'b1;
                exp_tick  = m_tick(c, Lc, Dc);
                exp_count = m_count(c, Lc, Dc);
            end
            chk("count", 32'(count), 32'(exp_count));
            chk("tick", 32'(tick), 32'(exp_tick));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("cfg_ready", 32'(cfg_ready), 32'(!exp_busy));
            accept = cfg_valid && !exp_busy;
            stop   = (c == s);
            start  = exp_busy ? 1'($urandom % 2) : 1'b0;
            step();
            if (accept) begin
                ms_limit  = hL;
                ms_per    = hper;
                ms_div    = hd;
                cfg_valid = 1'b0;
            end
        end
        stop  = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rl, rd, rs;
        bit rp;
        #1 ASYNCRESET = 1'b1;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        #5 ASYNCRESET = 1'b0;
        step();

        stop = 1'b1;
        step();
        chk("idle_stop_busy", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        chk("idle_startstop_busy", 32'(busy), 32'd0);
        chk("idle_startstop_count", 32'(count), 32'd0);
        start = 1'b0;
        stop  = 1'b0;

        // Power-on config (L=15 one-shot) governs a launch without a transfer.
        run_case(0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_case(1, 3, 0, 0, 0, 0, 0, 0, 0);
        run_case(1, 1, 1, 0, 9, 0, 0, 0, 0);
        run_case(1, 5, 0, 0, 3, 0, 0, 0, 0);
        run_case(0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_case(1, 5, 1, 0, 8, 1, 2, 0, 0);
        run_case(0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_case(1, 2, 1, 0, 3, 0, 0, 0, 0);
        run_case(1, 0, 1, 0, 6, 0, 0, 0, 0);
        run_case(1, 15, 1, 0, 20, 0, 0, 0, 0);
`ifdef COUNTER_RUN_CTRL_PRESCALE_EN
        run_case(1, 1, 0, 2, 0, 0, 0, 0, 0);
`else
        run_case(1, 1, 0, 0, 0, 0, 0, 0, 0);
`endif

        // Asynchronous reset mid-run, between clock edges.
        cfg_valid    = 1'b1;
        cfg_limit    = 4'd4;
        cfg_periodic = 1'b1;
`ifdef COUNTER_RUN_CTRL_PRESCALE_EN
        cfg_div      = 4'd0;
`endif
        start = 1'b1;
        step();
        start     = 1'b0;
        cfg_valid = 1'b0;
        step();
        step();
        chk("pre_rst_count", 32'(count), 32'd2);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #3 ASYNCRESET = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(cfg_ready), 32'd1);
        chk("arst_tick", 32'(tick), 32'd0);
        #2 ASYNCRESET = 1'b0;
        ms_limit = 15;
        ms_per   = 1'b0;
        ms_div   = 0;
        run_case(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            rl = $urandom_range(0, 15);
            rp = 1'($urandom % 2);
`ifdef COUNTER_RUN_CTRL_PRESCALE_EN
            rd = $urandom_range(0, 3);
`else
            rd = 0;
`endif
            rs = (($urandom % 3) == 0) ? 0 : $urandom_range(1, 40);
            run_case(1, rl, rp, rd, rs, 0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
- Sequencing controller for a WIDTH-bit up-counter datapath (incrementer plus register bank).
- Accepts a terminal-count configuration over a valid/ready handshake.
- Starts and stops the count, and emits a one-cycle tick at terminal count in one-shot or periodic mode.
- Sits between software/top-level control and the counter datapath, and provides the tick source for downstream schedulers.

Parameters:
- WIDTH, 4, counter and limit width in bits (≥1).
- DIV_WIDTH, 4, prescaler divisor width; used only when the optional feature is compiled in.

Ports:
- CLK  input  1  single clock, all state updates on posedge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  configuration offered.
- cfg_ready  output  1  controller can accept configuration.
- cfg_limit  input  WIDTH  terminal count L.
- cfg_periodic  input  1  1 = auto-restart after terminal count, 0 = one-shot.
- start  input  1  begin counting (level-sampled each cycle).
- stop  input  1  abort counting.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high while in RUN.
- tick  output  1  one-cycle pulse, registered, after terminal count.

Behaviour:
- Reset values: state=IDLE, count=0, busy=0, tick=0, cfg_ready=1, limit_q=all-ones, periodic_q=0. Assertion of ASYNCRESET at any time, including mid-RUN, forces these values immediately and discards the stored configuration.
- States are IDLE and RUN.
  - cfg_ready = (state==IDLE); busy = (state==RUN), driven from the state register.
- Configuration:
  - A transfer occurs on an edge where cfg_valid & cfg_ready.
  - limit_q <= cfg_limit and periodic_q <= cfg_periodic.
  - Configuration offered while in RUN is held off (cfg_ready=0); cfg_valid stays asserted until accepted.
- IDLE -> RUN:
  - Occurs on an edge with start=1 and stop=0. On that edge count <= 0.
  - If a configuration is accepted on the same edge, the new limit/mode governs this run.
  - start & stop together in IDLE: stop wins, the controller stays in IDLE.
  - stop alone in IDLE: ignored.
- In RUN, each edge:
  - If count==limit_q: count <= 0 and tick <= 1. If periodic_q, stay in RUN; else go to IDLE.
  - Otherwise count <= count+1 (modulo 2^WIDTH) and tick <= 0.
- Timing: one-shot run with limit L started at edge 0 has count=k during cycle k+1, k=0..L. tick is high and busy is low during cycle L+2.
- L=0 periodic: count stays 0 and tick is high every cycle from cycle 2 on.
- L=2^WIDTH-1: a full wrap; count never exceeds the width.
- stop in RUN:
  - Next edge goes to IDLE and count holds its value for readout; count is cleared on the next start.
  - If stop coincides with count==limit_q, tick still pulses, count <= 0, and the state goes to IDLE regardless of mode.
- start in RUN is ignored (no restart).
- tick is low in every cycle not defined above.

Optional Feature:
- Macro COUNTER_RUN_CTRL_PRESCALE_EN.
- Defined:
  - Adds input cfg_div[DIV_WIDTH] captured with the configuration; reset value 0.
  - An internal divider is cleared on IDLE->RUN. count advances or wraps only on edges where divider==div_q; the divider otherwise increments.
  - tick timing scales by (div_q+1).
  - stop takes effect on the next edge regardless of divider phase.
- Undefined: the cfg_div port and divider are absent, and count advances every cycle as specified above.

Decomposition:
- Package counter_run_ctrl_pkg:
  - state enum {IDLE, RUN} (1 bit).
  - Default WIDTH/DIV_WIDTH constants.
  - Reset-value constants for limit_q and periodic_q.
- Sub-module counter_run_ctrl_cnt holds the count register, incrementer with clear, and the count==limit compare. It has inputs clr, inc and limit, and outputs count and at_limit; the FSM lives in the parent.

Test Plan:
- Reset, then cfg limit=3, periodic=0, then start pulse -> count 0,1,2,3 in cycles 1-4; tick=1 only in cycle 5; busy low from cycle 5; count=0.
- cfg limit=1, periodic=1, start -> tick every 2nd cycle (cycles 3,5,7,...), busy stays 1 until stop, then IDLE one edge later.
- Mid-run stop at count=2 (limit=5) -> IDLE next cycle, count holds 2, no tick; next start restarts at 0.
- cfg_valid held during RUN -> cfg_ready=0 and limit unchanged until IDLE, then accepted in the first IDLE cycle. start+stop together in IDLE -> stays IDLE.
- Limit=15 (WIDTH=4), periodic -> count reaches 15, wraps to 0 with tick; ASYNCRESET asserted mid-run -> count=0, busy=0, cfg_ready=1 without a clock edge, limit back to 15.
- With COUNTER_RUN_CTRL_PRESCALE_EN, div=2, limit=1, one-shot -> count increments every 3 cycles; tick after 6 count cycles; without the macro the same config ticks in cycle 3.
